// File: rtl/booth_product_accumulator.sv
// Saturating signed accumulator for a stream of Booth multiplier products.
// A programmed count of products is summed and the result is held on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start; last result and overflow flag kept visible
// ACCUM | accepting products until the programmed count is reached
// HOLD  | final sum presented on acc_out until acc_ready

module booth_product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic [ACC_W:0]    sum_wide;
  logic              sat_pos;
  logic              sat_neg;
  logic [ACC_W-1:0]  sum_sat;

  // One guard bit: the top two bits disagree exactly when the true sum leaves the ACC_W range.
  always_comb begin
    sum_wide = {acc_out[ACC_W-1], acc_out}
             + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    sat_pos  = ~sum_wide[ACC_W] &  sum_wide[ACC_W-1];
    sat_neg  =  sum_wide[ACC_W] & ~sum_wide[ACC_W-1];
    if (sat_pos) begin
      sum_sat = ACC_MAX;
    end else if (sat_neg) begin
      sum_sat = ACC_MIN;
    end else begin
      sum_sat = sum_wide[ACC_W-1:0];
    end
  end

  assign prod_ready = (state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out   <= '0;
            overflow  <= 1'b0;
            remaining <= len;
            busy      <= 1'b1;
            if (len == '0) begin
              state     <= HOLD;
              acc_valid <= 1'b1;
            end else begin
              state     <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc_out   <= sum_sat;
            remaining <= remaining - LEN_W'(1);
            if (sat_pos || sat_neg) begin
              overflow <= 1'b1;
            end
            if (remaining == LEN_W'(1)) begin
              state     <= HOLD;
              acc_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator: a 24-bit instance for the main runs
// and an 18-bit instance for saturation, sharing the product/result handshake inputs.

module tb_booth_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        s_start;
  logic [7:0]  len;
  logic        prod_valid;
  logic [15:0] prod;
  logic        acc_ready;

  logic        prod_ready, acc_valid, overflow, busy;
  logic [23:0] acc_out;
  logic        s_prod_ready, s_acc_valid, s_overflow, s_busy;
  logic [17:0] s_acc_out;

  int errors = 0;
  int checks = 0;

  booth_product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .overflow(overflow), .busy(busy)
  );

  booth_product_accumulator #(.PROD_W(16), .ACC_W(18), .LEN_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(s_prod_ready),
    .acc_out(s_acc_out), .acc_valid(s_acc_valid), .acc_ready(acc_ready),
    .overflow(s_overflow), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_start = 1'b0; len = '0;
    prod_valid = 1'b0; prod = '0; acc_ready = 1'b0;
    #2;
    check("rst_acc_out",    32'(acc_out),    32'h0);
    check("rst_acc_valid",  32'(acc_valid),  32'h0);
    check("rst_prod_ready", 32'(prod_ready), 32'h0);
    check("rst_overflow",   32'(overflow),   32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    #21 rst_n = 1'b1;
    tick();

    // Basic run: 100 - 50 + 7 = 57
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    check("basic_ready", 32'(prod_ready), 32'h1);
    check("basic_busy",  32'(busy),       32'h1);
    prod_valid = 1'b1; prod = 16'd100;
    tick();
    prod = -16'sd50;
    tick();
    prod = 16'd7;
    tick();
    prod_valid = 1'b0;
    check("basic_valid",    32'(acc_valid),  32'h1);
    check("basic_sum",      32'(acc_out),    32'h39);
    check("basic_overflow", 32'(overflow),   32'h0);
    check("basic_hold_rdy", 32'(prod_ready), 32'h0);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("basic_idle_valid", 32'(acc_valid), 32'h0);
    check("basic_idle_keep",  32'(acc_out),   32'h39);

    // Zero length, with a product offered alongside start
    start = 1'b1; len = 8'd0; prod_valid = 1'b1; prod = 16'd55;
    tick();
    start = 1'b0;
    check("zero_valid", 32'(acc_valid), 32'h1);
    check("zero_sum",   32'(acc_out),   32'h0);
    tick();
    check("zero_hold_sum", 32'(acc_out), 32'h0);
    prod_valid = 1'b0; acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;

    // Gaps: valid pattern 1,0,0,1,1,0,1 -> 10 - 3 + 1000 + 2 = 1009
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = 16'd10;   tick();
    prod_valid = 1'b0; prod = 16'd999;  tick();
    tick();
    prod_valid = 1'b1; prod = -16'sd3;  tick();
    prod = 16'd1000;                    tick();
    prod_valid = 1'b0; prod = 16'd999;  tick();
    check("gap_still_accum", 32'(prod_ready), 32'h1);
    prod_valid = 1'b1; prod = 16'd2;    tick();
    prod_valid = 1'b0;
    check("gap_valid", 32'(acc_valid), 32'h1);
    check("gap_sum",   32'(acc_out),   32'h3F1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 8'd7;
      tick();
      check("stall_valid", 32'(acc_valid), 32'h1);
      check("stall_sum",   32'(acc_out),   32'h3F1);
    end
    start = 1'b0; acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("stall_idle_valid", 32'(acc_valid), 32'h0);
    check("stall_idle_busy",  32'(busy),      32'h0);
    check("stall_idle_sum",   32'(acc_out),   32'h3F1);

    // Async reset after two accepts, then a fresh run 3 + 4
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod = 16'd1;
    tick();
    prod = 16'd2;
    tick();
    prod_valid = 1'b0;
    check("pre_reset_sum", 32'(acc_out), 32'h3);
    #3 rst_n = 1'b0;
    #1;
    check("areset_sum",   32'(acc_out),    32'h0);
    check("areset_busy",  32'(busy),       32'h0);
    check("areset_ready", 32'(prod_ready), 32'h0);
    #1 rst_n = 1'b1;
    tick();
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod = 16'd3;
    tick();
    prod = 16'd4;
    tick();
    prod_valid = 1'b0;
    check("post_reset_valid", 32'(acc_valid), 32'h1);
    check("post_reset_sum",   32'(acc_out),   32'h7);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;

    // Back-to-back single-product runs
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod = 16'hFFFF;
    tick();
    prod_valid = 1'b0;
    check("b2b_first_sum", 32'(acc_out), 32'hFFFFFF);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0; start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    check("b2b_cleared", 32'(acc_out), 32'h0);
    prod_valid = 1'b1; prod = 16'd5;
    tick();
    prod_valid = 1'b0;
    check("b2b_second_valid", 32'(acc_valid), 32'h1);
    check("b2b_second_sum",   32'(acc_out),   32'h5);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;

    // Saturation on the 18-bit instance: 9 x 16384 clamps to 0x1FFFF
    s_start = 1'b1; len = 8'd9;
    tick();
    s_start = 1'b0; prod_valid = 1'b1; prod = 16'd16384;
    for (int i = 0; i < 9; i++) tick();
    prod_valid = 1'b0;
    check("sat_pos_valid", 32'(s_acc_valid), 32'h1);
    check("sat_pos_sum",   32'(s_acc_out),   32'h1FFFF);
    check("sat_pos_ovf",   32'(s_overflow),  32'h1);
    check("main_untouched", 32'(busy), 32'h0);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0; s_start = 1'b1; len = 8'd9;
    tick();
    s_start = 1'b0;
    check("sat_ovf_cleared", 32'(s_overflow), 32'h0);
    check("sat_sum_cleared", 32'(s_acc_out),  32'h0);
    prod_valid = 1'b1; prod = -16'sd16384;
    for (int i = 0; i < 8; i++) tick();
    check("sat_neg_exact_min", 32'(s_acc_out),  32'h20000);
    check("sat_neg_no_ovf",    32'(s_overflow), 32'h0);
    tick();
    prod_valid = 1'b0;
    check("sat_neg_sum",   32'(s_acc_out),   32'h20000);
    check("sat_neg_ovf",   32'(s_overflow),  32'h1);
    check("sat_neg_valid", 32'(s_acc_valid), 32'h1);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("sat_ovf_sticky_idle", 32'(s_overflow), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_product_accumulator.md
Name: booth_product_accumulator

Overview:
- Downstream consumer of the 8x8 signed Booth multiplier's 16-bit product.
- Accepts a programmed number of signed products over a valid/ready handshake and sign-extends each one.
- Accumulates the products into a wider saturating register.
- Presents the final sum on an output handshake, forming the accumulate half of a sequential MAC datapath.

Parameters:
- PROD_W, 16, width of the incoming signed product.
- ACC_W, 24, width of the signed accumulator and result (must be > PROD_W).
- LEN_W, 8, width of the product-count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new accumulation (honoured only in IDLE).
- len  input  LEN_W  number of products to accumulate; sampled on an accepted start.
- prod_valid  input  1  product available from the multiplier.
- prod  input  PROD_W  signed product, two's complement.
- prod_ready  output  1  block accepts a product this cycle.
- acc_out  output  ACC_W  signed accumulated result.
- acc_valid  output  1  acc_out holds a final result.
- acc_ready  input  1  downstream takes the result.
- overflow  output  1  sticky flag: saturation occurred during the current run.
- busy  output  1  high in ACCUM and HOLD.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc_out=0; acc_valid=0; prod_ready=0; overflow=0; busy=0; internal remaining count=0.
  - Takes effect immediately, including mid-ACCUM or mid-HOLD; a partial sum is discarded.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - prod_ready=0, acc_valid=0, busy=0.
  - On start=1: acc_out<=0, overflow<=0, remaining<=len.
  - Next state: HOLD if len==0, else ACCUM.
  - prod_valid is ignored in IDLE.
- ACCUM:
  - prod_ready=1 (combinational from state); busy=1.
  - A product is accepted on a cycle with prod_valid&&prod_ready.
  - On accept: acc_out<=sat(acc_out + sext(prod)); remaining<=remaining-1.
  - If the accepted product is the last one (remaining==1), next state is HOLD.
  - Cycles with prod_valid=0 change nothing; gaps of any length are allowed.
- HOLD:
  - acc_valid=1; acc_out and overflow held stable; prod_ready=0; busy=1.
  - On acc_ready=1: acc_valid drops next cycle and state returns to IDLE.
  - acc_out and overflow retain their values in IDLE until the next start.
- start outside IDLE is ignored, with no effect on count or sum.
- Arithmetic:
  - Sum is formed at ACC_W+1 bits from sign-extended operands.
  - Positive overflow clamps to 2^(ACC_W-1)-1 and sets overflow.
  - Negative overflow clamps to -2^(ACC_W-1) and sets overflow.
  - Once saturated, later products continue to be added to the clamped value (no lock).
  - overflow is sticky until the next accepted start.
- Latency:
  - Product accepted at edge k appears in acc_out after edge k.
  - acc_valid rises on the same edge that absorbs the last product.
  - len==0 gives acc_valid one cycle after start, with acc_out=0.
- Back-to-back runs: start may be asserted the cycle after the acc_valid/acc_ready handshake (IDLE); there is no dead cycle beyond that.
- start and prod_valid asserted in the same IDLE cycle: the product is not accepted; the first product can be accepted in the cycle after start.

Test Plan:
- Basic run: start, len=3; products 100, -50, 7 with prod_valid high -> acc_valid=1 after the 3rd accept, acc_out=57 (0x000039), overflow=0, prod_ready=0 during HOLD.
- Zero length: start, len=0 -> next cycle acc_valid=1, acc_out=0, and no product is accepted even if prod_valid=1.
- Saturation (ACC_W=18): len=9, each product 16384 (-128 x -128) -> acc_out=131071 (0x1FFFF), overflow=1. Second run with len=9 and products -16384 -> acc_out=-131072, overflow cleared at start then set again.
- Backpressure and gaps:
  - len=4; prod_valid toggles 1,0,0,1,1,0,1 -> exactly 4 accepts and the correct sum.
  - Hold acc_ready=0 for 5 cycles -> acc_out stable, acc_valid=1.
  - A start pulse during HOLD is ignored; acc_ready=1 -> returns to IDLE.
- Async reset mid-run: len=5, assert rst_n=0 after 2 accepts, between clock edges -> acc_out=0, busy=0, prod_ready=0 immediately. After release, start with len=2, products 3 and 4 -> acc_out=7.
- Back-to-back: complete the len=1 run (product -1 -> acc_out=-1), then start on the next cycle with len=1 and product 5 -> acc_out=5 and the previous sum is not carried over.
